// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_ctrl
//  Brief    : Word-addressed data memory with req/ready/done handshake,
//             programmable access latency and per-byte write enables.
//             Optional macro ALIGN_CHECK_EN enables misalignment faults on Err.
//  Revision : 1.0 - initial release
// ============================================================================
module data_memory_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Req,
    input  logic                  WEn,
    input  logic [DATA_W/8-1:0]   ByteEn,
    input  logic [ADDR_W-1:0]     Address,
    input  logic [DATA_W-1:0]     Wdata,
    output logic [DATA_W-1:0]     Rdata,
    output logic                  Ready,
    output logic                  Done,
    output logic                  Err
);

    localparam int               c_NB       = DATA_W / 8;
    localparam int               c_IW       = $clog2(DEPTH);
    localparam logic [3:0]       c_CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [c_NB-1:0]  c_WORD_BE  = {c_NB{1'b1}};
    localparam logic [c_NB-1:0]  c_HALF_LO  = c_WORD_BE >> (c_NB - c_NB / 2);
    localparam logic [c_NB-1:0]  c_HALF_HI  = c_WORD_BE << (c_NB - c_NB / 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [c_IW-1:0]     idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                wen_q;
    logic [c_NB-1:0]     be_q;
    logic                mis_q;
    logic                ready_q;
    logic                done_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                w_accept;
    logic                w_mis;
    logic [c_IW-1:0]     w_in_idx;
    logic                w_exec;
    logic                w_ex_wen;
    logic                w_ex_mis;
    logic [c_IW-1:0]     w_ex_idx;
    logic [DATA_W-1:0]   w_ex_wdata;
    logic [c_NB-1:0]     w_ex_be;

    // Upper address bits only wrap the index; byte offset matters only for checks.
    logic w_unused_addr;
    assign w_unused_addr = ^{Address[ADDR_W-1:c_IW+2], Address[1:0]};

    assign w_in_idx = Address[2 +: c_IW];
    // A request is taken whenever the block is not busy counting (IDLE or DONE).
    assign w_accept = Req && (state_q != S_WAIT);

`ifdef ALIGN_CHECK_EN
    assign w_mis = ((ByteEn == c_WORD_BE) && (Address[1:0] != 2'b00)) ||
                   (((ByteEn == c_HALF_LO) || (ByteEn == c_HALF_HI)) && Address[0]);
`else
    assign w_mis = 1'b0;
`endif

    // With single-cycle latency the access executes on the acceptance edge using
    // the live inputs; otherwise it executes from the latched copies when the
    // counter is about to reach zero.
    generate
        if (LATENCY == 1) begin : g_lat_one
            assign w_exec     = w_accept;
            assign w_ex_wen   = WEn;
            assign w_ex_mis   = w_mis;
            assign w_ex_idx   = w_in_idx;
            assign w_ex_wdata = Wdata;
            assign w_ex_be    = ByteEn;
        end else begin : g_lat_multi
            assign w_exec     = (state_q == S_WAIT) && (cnt_q == 4'd1);
            assign w_ex_wen   = wen_q;
            assign w_ex_mis   = mis_q;
            assign w_ex_idx   = idx_q;
            assign w_ex_wdata = wdata_q;
            assign w_ex_be    = be_q;
        end
    endgenerate

    // Handshake FSM: state, latency counter, latched request and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            be_q    <= '0;
            mis_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= S_DONE;
                        cnt_q   <= 4'd0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        err_q   <= mis_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        idx_q   <= w_in_idx;
                        wdata_q <= Wdata;
                        wen_q   <= WEn;
                        be_q    <= ByteEn;
                        mis_q   <= w_mis;
                        cnt_q   <= c_CNT_LOAD;
                        if (LATENCY == 1) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                            err_q   <= w_mis;
                        end else begin
                            state_q <= S_WAIT;
                            ready_q <= 1'b0;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
            endcase
            if (w_exec && !w_ex_wen) begin
                rdata_q <= w_ex_mis ? '0 : mem_q[w_ex_idx];
            end
        end
    end

    // Storage array: byte-lane writes at the execute edge, suppressed by reset.
    always_ff @(posedge CLK) begin
        if (!RST && w_exec && w_ex_wen && !w_ex_mis) begin
            for (int i = 0; i < c_NB; i++) begin
                if (w_ex_be[i]) begin
                    mem_q[w_ex_idx][8*i +: 8] <= w_ex_wdata[8*i +: 8];
                end
            end
        end
    end

    assign Rdata = rdata_q;
    assign Ready = ready_q;
    assign Done  = done_q;
    assign Err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_memory_ctrl
//  Brief    : Scoreboard bench for data_memory_ctrl (LATENCY=2 and LATENCY=3
//             instances). Honours ALIGN_CHECK_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_memory_ctrl;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wen, req3, wen3;
    logic [3:0]  be, be3;
    logic [31:0] addr, wdata, addr3, wdata3;
    logic [31:0] rdata, rdata3;
    logic        ready, done, err, ready3, done3, err3;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(2)) u_dut (
        .CLK(clk), .RST(rst), .Req(req), .WEn(wen), .ByteEn(be), .Address(addr),
        .Wdata(wdata), .Rdata(rdata), .Ready(ready), .Done(done), .Err(err)
    );

    data_memory_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(3)) u_dut3 (
        .CLK(clk), .RST(rst), .Req(req3), .WEn(wen3), .ByteEn(be3), .Address(addr3),
        .Wdata(wdata3), .Rdata(rdata3), .Ready(ready3), .Done(done3), .Err(err3)
    );

    typedef struct {
        int          acc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb2[$];
    exp_t        sb3[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc   = 0;
    int          low3  = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] exp_last = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic misal(input logic [31:0] a, input logic [3:0] b);
`ifdef ALIGN_CHECK_EN
        if (b == 4'hF) return (a[1:0] != 2'b00);
        if (b == 4'h3 || b == 4'hC) return a[0];
        return 1'b0;
`else
        return 1'b0 & a[0] & b[0];
`endif
    endfunction

    // Scoreboard check for the LATENCY=2 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb2.size() == 0) begin
                check_eq("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                e = sb2.pop_front();
                check_eq("latency", 32'(cyc - e.acc), 32'd2);
                check_eq("rdata", rdata, e.rdata);
                check_eq("err", {31'd0, err}, {31'd0, e.err});
                check_eq("ready_in_done", {31'd0, ready}, 32'd1);
            end
        end
    end

    // Scoreboard check for the LATENCY=3 instance, including Ready-low spacing.
    always @(negedge clk) begin
        exp_t e;
        if (ready3 === 1'b0) low3++;
        if (rst === 1'b0 && done3 === 1'b1) begin
            if (sb3.size() == 0) begin
                check_eq("spurious_done3", {31'd0, done3}, 32'd0);
            end else begin
                e = sb3.pop_front();
                check_eq("latency3", 32'(cyc - e.acc), 32'd3);
                check_eq("rdata3", rdata3, e.rdata);
                check_eq("err3", {31'd0, err3}, {31'd0, e.err});
                check_eq("b2b_ready_low", 32'(low3), 32'd2);
            end
            low3 = 0;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Issue one access on the LATENCY=2 instance and wait for its Done.
    task automatic access(input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] d);
        exp_t e;
        int   t;
        int   idx;
        logic m;
        t = 0;
        while (ready !== 1'b1 && t < 20) begin step(); t++; end
        check_eq("ready_before_req", {31'd0, ready}, 32'd1);
        m   = misal(a, b);
        idx = int'(a[9:2]);
        e.acc = cyc;
        e.err = m;
        if (w) begin
            e.rdata = exp_last;
            if (!m) begin
                for (int i = 0; i < 4; i++) if (b[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
            end
        end else begin
            e.rdata  = m ? 32'h0 : mdl[idx];
            exp_last = e.rdata;
        end
        sb2.push_back(e);
        req = 1'b1; wen = w; be = b; addr = a; wdata = d;
        step();
        // Scramble everything while busy; the latched request must be used.
        req = 1'b0; wen = 1'($urandom); be = 4'($urandom); addr = $urandom; wdata = $urandom;
        t = 0;
        while (sb2.size() != 0 && t < 20) begin step(); t++; end
        if (sb2.size() != 0) begin
            check_eq("done_timeout", 32'(sb2.size()), 32'd0);
            sb2.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        rst = 1'b1;
        req = 1'b0; wen = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
        req3 = 1'b0; wen3 = 1'b0; be3 = 4'h0; addr3 = 32'h0; wdata3 = 32'h0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
        repeat (3) step();
        rst = 1'b0;
        check_eq("rst_ready", {31'd0, ready}, 32'd1);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_ready3", {31'd0, ready3}, 32'd1);

        // Idle with Req low: no Done, stays ready.
        repeat (4) step();
        check_eq("idle_ready", {31'd0, ready}, 32'd1);

        // Basic write/read.
        access(32'h0, 1'b1, 4'hF, 32'h0000_0002);
        access(32'h0, 1'b0, 4'hF, 32'h0);
        check_eq("t1_rdata", rdata, 32'h0000_0002);

        // Write with no byte lanes leaves memory untouched; ByteEn ignored on read.
        access(32'h0, 1'b1, 4'h0, 32'hFFFF_FFFF);
        access(32'h0, 1'b0, 4'h0, 32'h0);
        check_eq("be0_rdata", rdata, 32'h0000_0002);

        // Byte and half-word merges.
        access(32'h14, 1'b1, 4'hF, 32'hAABB_CCDD);
        access(32'h14, 1'b1, 4'h2, 32'h0000_1100);
        access(32'h14, 1'b0, 4'hF, 32'h0);
        check_eq("t2_rdata", rdata, 32'hAABB_11DD);
        access(32'h14, 1'b1, 4'hC, 32'h1234_0000);
        access(32'h14, 1'b0, 4'hF, 32'h0);
        check_eq("half_rdata", rdata, 32'h1234_11DD);

        // Address wrap modulo DEPTH words.
        access(32'h400, 1'b1, 4'hF, 32'h1234_5678);
        access(32'h0, 1'b0, 4'hF, 32'h0);
        check_eq("t4_wrap", rdata, 32'h1234_5678);

        // Reset in WAIT aborts the write.
        access(32'h8, 1'b1, 4'hF, 32'h0);
        req = 1'b1; wen = 1'b1; be = 4'hF; addr = 32'h8; wdata = 32'hDEAD_BEEF;
        step();
        req = 1'b0;
        check_eq("t5_busy", {31'd0, ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_last = 32'h0;
        check_eq("t5_rst_ready", {31'd0, ready}, 32'd1);
        check_eq("t5_rst_done", {31'd0, done}, 32'd0);
        check_eq("t5_rst_rdata", rdata, 32'h0);
        access(32'h8, 1'b0, 4'hF, 32'h0);
        check_eq("t5_rdata", rdata, 32'h0);

        // Misalignment handling (build-dependent expectations).
        access(32'h4, 1'b1, 4'hF, 32'h1111_1111);
        access(32'h6, 1'b1, 4'hF, 32'hCAFE_F00D);
        access(32'h4, 1'b0, 4'hF, 32'h0);
`ifdef ALIGN_CHECK_EN
        check_eq("t6_rdata", rdata, 32'h1111_1111);
`else
        check_eq("t6_rdata", rdata, 32'hCAFE_F00D);
`endif
        access(32'h5, 1'b1, 4'h3, 32'h0000_7777);
        access(32'h6, 1'b1, 4'hC, 32'h5555_0000);
        access(32'h5, 1'b0, 4'hF, 32'h0);
        access(32'h4, 1'b0, 4'hF, 32'h0);

        // Back-to-back on LATENCY=3 with Req held from each DONE cycle.
        step();
        low3 = 0;
        sb3.push_back('{acc: cyc, rdata: 32'h0, err: 1'b0});
        req3 = 1'b1; wen3 = 1'b1; be3 = 4'hF; addr3 = 32'h0; wdata3 = 32'h5A5A_0003;
        for (int k = 0; k < 3; k++) begin
            repeat (3) step();
            sb3.push_back('{acc: cyc, rdata: 32'h5A5A_0003, err: 1'b0});
            wen3  = 1'b0;
            addr3 = (k == 1) ? 32'h400 : 32'h0;
        end
        step();
        req3 = 1'b0;
        t = 0;
        while (sb3.size() != 0 && t < 20) begin step(); t++; end
        check_eq("b2b_drained", 32'(sb3.size()), 32'd0);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
